// File: rtl/anabellek_yanitlayici_pkg.sv
// Shared definitions for the main-memory responder: line geometry and FSM state codes.
`default_nettype none

package anabellek_yanitlayici_pkg;

  localparam int SATIR_BIT_VARSAYILAN = 256;
  localparam int OFSET_BIT            = 5;

  typedef logic [1:0] durum_t;

  localparam logic [1:0] BOSTA = 2'd0;
  localparam logic [1:0] BEKLE = 2'd1;
  localparam logic [1:0] YANIT = 2'd2;

  function automatic int sayac_genisligi(input int gecikme);
    return (gecikme > 1) ? $clog2(gecikme) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/anabellek_yanitlayici_if.sv
// Cache<->memory line link: request channel and read-response channel, each valid/ready.
`default_nettype none

interface anabellek_yanitlayici_if
  import anabellek_yanitlayici_pkg::*;
#(
  parameter int ADRES_BIT = 32,
  parameter int SATIR_BIT = SATIR_BIT_VARSAYILAN
);
  logic [ADRES_BIT-1:0] istek_adres_i;
  logic [SATIR_BIT-1:0] istek_veri_i;
  logic                 istek_gecerli_i;
  logic                 istek_yaz_gecerli_i;
  logic                 istek_hazir_o;
  logic [SATIR_BIT-1:0] yanit_veri_o;
  logic                 yanit_gecerli_o;
  logic                 yanit_hazir_i;

  modport master (
    output istek_adres_i, istek_veri_i, istek_gecerli_i, istek_yaz_gecerli_i, yanit_hazir_i,
    input  istek_hazir_o, yanit_veri_o, yanit_gecerli_o
  );

  modport slave (
    input  istek_adres_i, istek_veri_i, istek_gecerli_i, istek_yaz_gecerli_i, yanit_hazir_i,
    output istek_hazir_o, yanit_veri_o, yanit_gecerli_o
  );
endinterface

`default_nettype wire

// File: rtl/anabellek_yanitlayici_bellek_dizisi.sv
// bellek_dizisi: single-port line RAM, synchronous write and synchronous read.
`default_nettype none

module bellek_dizisi #(
  parameter int SATIR_BIT    = 256,
  parameter int SATIR_SAYISI = 1024,
  parameter int INDEKS_BIT   = $clog2(SATIR_SAYISI)
) (
  input  logic                  clk_i,
  input  logic                  yaz_i,
  input  logic [INDEKS_BIT-1:0] adres_i,
  input  logic [SATIR_BIT-1:0]  veri_i,
  output logic [SATIR_BIT-1:0]  veri_o
);

  logic [SATIR_BIT-1:0] bellek_q [SATIR_SAYISI];
  logic [SATIR_BIT-1:0] okuma_q;

  always_ff @(posedge clk_i) begin
    if (yaz_i) begin
      bellek_q[adres_i] <= veri_i;
    end
    okuma_q <= bellek_q[adres_i];
  end

  assign veri_o = okuma_q;

endmodule

`default_nettype wire

// File: rtl/anabellek_yanitlayici.sv
// anabellek_yanitlayici: fixed-latency main-memory responder for 256-bit line requests.
`default_nettype none

module anabellek_yanitlayici
  import anabellek_yanitlayici_pkg::*;
#(
  parameter int ADRES_BIT    = 32,
  parameter int SATIR_BIT    = SATIR_BIT_VARSAYILAN,
  parameter int SATIR_SAYISI = 1024,
  parameter int GECIKME      = 8
) (
  input logic                  clk_i,
  input logic                  rst_i,
  anabellek_yanitlayici_if.slave bus
);

  localparam int INDEKS_BIT = $clog2(SATIR_SAYISI);
  localparam int SAYAC_BIT  = sayac_genisligi(GECIKME);

  durum_t                durum_q, durum_d;
  logic [SAYAC_BIT-1:0]  sayac_q, sayac_d;
  logic [INDEKS_BIT-1:0] indeks_q, indeks_d;
  logic [SATIR_BIT-1:0]  veri_q, veri_d;
  logic                  yaz_q, yaz_d;
  logic                  hazir_q, hazir_d;
  logic                  yanit_gecerli_q, yanit_gecerli_d;
  logic [SATIR_BIT-1:0]  yanit_veri_q, yanit_veri_d;

  logic [INDEKS_BIT-1:0] w_istek_indeks;
  logic [INDEKS_BIT-1:0] w_ram_adres;
  logic [SATIR_BIT-1:0]  w_ram_veri;
  logic                  w_ram_yaz;
  logic                  w_adres_unused;

  // Offset bits and aliasing high bits of the address are intentionally dropped.
  assign w_istek_indeks = bus.istek_adres_i[OFSET_BIT +: INDEKS_BIT];
  assign w_adres_unused = ^bus.istek_adres_i;

  // While idle the RAM is pointed at the incoming address so the line is already
  // read out by the accept edge, which keeps GECIKME=1 exact.
  assign w_ram_adres = (durum_q == BOSTA) ? w_istek_indeks : indeks_q;

  bellek_dizisi #(
    .SATIR_BIT    (SATIR_BIT),
    .SATIR_SAYISI (SATIR_SAYISI),
    .INDEKS_BIT   (INDEKS_BIT)
  ) u_bellek_dizisi (
    .clk_i   (clk_i),
    .yaz_i   (w_ram_yaz),
    .adres_i (w_ram_adres),
    .veri_i  (veri_q),
    .veri_o  (w_ram_veri)
  );

  always_comb begin
    durum_d         = durum_q;
    sayac_d         = sayac_q;
    indeks_d        = indeks_q;
    veri_d          = veri_q;
    yaz_d           = yaz_q;
    yanit_gecerli_d = yanit_gecerli_q;
    yanit_veri_d    = yanit_veri_q;
    w_ram_yaz       = 1'b0;

    case (durum_q)
      BOSTA: begin
        if (hazir_q && bus.istek_gecerli_i) begin
          indeks_d = w_istek_indeks;
          veri_d   = bus.istek_veri_i;
          yaz_d    = bus.istek_yaz_gecerli_i;
          sayac_d  = SAYAC_BIT'(GECIKME - 1);
          durum_d  = BEKLE;
        end
      end
      BEKLE: begin
        if (sayac_q == '0) begin
          if (yaz_q) begin
            w_ram_yaz = !rst_i;
            durum_d   = BOSTA;
          end else begin
            yanit_veri_d    = w_ram_veri;
            yanit_gecerli_d = 1'b1;
            durum_d         = YANIT;
          end
        end else begin
          sayac_d = sayac_q - 1'b1;
        end
      end
      YANIT: begin
        if (bus.yanit_hazir_i) begin
          yanit_gecerli_d = 1'b0;
          durum_d         = BOSTA;
        end
      end
      default: durum_d = BOSTA;
    endcase

    hazir_d = (durum_d == BOSTA);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q         <= BOSTA;
      sayac_q         <= '0;
      hazir_q         <= 1'b0;
      yanit_gecerli_q <= 1'b0;
      yanit_veri_q    <= '0;
      yaz_q           <= 1'b0;
      indeks_q        <= '0;
      veri_q          <= '0;
    end else begin
      durum_q         <= durum_d;
      sayac_q         <= sayac_d;
      hazir_q         <= hazir_d;
      yanit_gecerli_q <= yanit_gecerli_d;
      yanit_veri_q    <= yanit_veri_d;
      yaz_q           <= yaz_d;
      indeks_q        <= indeks_d;
      veri_q          <= veri_d;
    end
  end

  assign bus.istek_hazir_o   = hazir_q;
  assign bus.yanit_gecerli_o = yanit_gecerli_q;
  assign bus.yanit_veri_o    = yanit_veri_q;

endmodule

`default_nettype wire

// File: tb/tb_anabellek_yanitlayici.sv
// Directed plus randomized checks of the memory responder against a line-array model.
`default_nettype none

module tb_anabellek_yanitlayici;

  localparam int G     = 8;
  localparam int SATIR = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [255:0] model [SATIR];

  anabellek_yanitlayici_if #(.ADRES_BIT(32), .SATIR_BIT(256)) bus ();

  anabellek_yanitlayici #(
    .ADRES_BIT(32), .SATIR_BIT(256), .SATIR_SAYISI(SATIR), .GECIKME(G)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kontrol(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int indeks(input logic [31:0] a);
    return int'((a / 32) % SATIR);
  endfunction

  function automatic logic [255:0] rastgele_satir();
    logic [255:0] s;
    for (int i = 0; i < 8; i++) s[i*32 +: 32] = $urandom;
    return s;
  endfunction

  task automatic cop_sur(input bit cop);
    if (cop) begin
      bus.istek_adres_i       = $urandom;
      bus.istek_veri_i        = rastgele_satir();
      bus.istek_gecerli_i     = 1'b1;
      bus.istek_yaz_gecerli_i = 1'($urandom);
    end
  endtask

  task automatic hazir_bekle(input string tag);
    int n = 0;
    while (bus.istek_hazir_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    kontrol(tag, {255'd0, bus.istek_hazir_o}, 256'd1);
  endtask

  task automatic yaz(input logic [31:0] adres, input logic [255:0] veri, input bit cop);
    hazir_bekle("yaz_hazir");
    bus.istek_adres_i       = adres;
    bus.istek_veri_i        = veri;
    bus.istek_yaz_gecerli_i = 1'b1;
    bus.istek_gecerli_i     = 1'b1;
    tick();
    bus.istek_gecerli_i = 1'b0;
    model[indeks(adres)] = veri;
    for (int k = 1; k <= G; k++) begin
      cop_sur(cop);
      tick();
      kontrol("yaz_hazir_zaman", {255'd0, bus.istek_hazir_o}, {255'd0, k == G});
      kontrol("yaz_yanit_yok", {255'd0, bus.yanit_gecerli_o}, 256'd0);
    end
    bus.istek_gecerli_i = 1'b0;
  endtask

  task automatic oku(input logic [31:0] adres, input int bekleme, input bit cop);
    logic [255:0] beklenen;
    beklenen = model[indeks(adres)];
    hazir_bekle("oku_hazir");
    bus.istek_adres_i       = adres;
    bus.istek_veri_i        = rastgele_satir();
    bus.istek_yaz_gecerli_i = 1'b0;
    bus.istek_gecerli_i     = 1'b1;
    bus.yanit_hazir_i       = (bekleme == 0);
    tick();
    bus.istek_gecerli_i = 1'b0;
    for (int k = 1; k <= G; k++) begin
      cop_sur(cop);
      tick();
      kontrol("oku_gecerli_zaman", {255'd0, bus.yanit_gecerli_o}, {255'd0, k == G});
    end
    bus.istek_gecerli_i = 1'b0;
    kontrol("oku_veri", bus.yanit_veri_o, beklenen);
    for (int s = 0; s < bekleme; s++) begin
      tick();
      kontrol("bekle_gecerli", {255'd0, bus.yanit_gecerli_o}, 256'd1);
      kontrol("bekle_veri", bus.yanit_veri_o, beklenen);
      kontrol("bekle_hazir", {255'd0, bus.istek_hazir_o}, 256'd0);
    end
    bus.yanit_hazir_i = 1'b1;
    tick();
    kontrol("oku_gecerli_dusus", {255'd0, bus.yanit_gecerli_o}, 256'd0);
    kontrol("oku_sonra_hazir", {255'd0, bus.istek_hazir_o}, 256'd1);
  endtask

  initial begin
    logic [255:0] eski;
    logic [255:0] satir;
    logic [31:0]  a;
    for (int i = 0; i < SATIR; i++) model[i] = '0;
    bus.istek_adres_i       = '0;
    bus.istek_veri_i        = '0;
    bus.istek_gecerli_i     = 1'b0;
    bus.istek_yaz_gecerli_i = 1'b0;
    bus.yanit_hazir_i       = 1'b1;

    // Reset held for 10 cycles.
    rst = 1'b1;
    repeat (10) tick();
    kontrol("rst_hazir", {255'd0, bus.istek_hazir_o}, 256'd0);
    kontrol("rst_gecerli", {255'd0, bus.yanit_gecerli_o}, 256'd0);
    kontrol("rst_veri", bus.yanit_veri_o, 256'd0);
    rst = 1'b0;
    tick();
    kontrol("rst_sonra_hazir", {255'd0, bus.istek_hazir_o}, 256'd1);

    // Write then read one line.
    yaz(32'h0000_0040, {8{32'hABCD_0010}}, 1'b0);
    oku(32'h0000_0040, 0, 1'b0);
    kontrol("yaz_oku_sabit", model[2], {8{32'hABCD_0010}});

    // Offset and high-bit aliasing map 0x803F onto line 1.
    satir = rastgele_satir();
    yaz(32'h0000_0020, satir, 1'b0);
    oku(32'h0000_803F, 0, 1'b0);

    // Response backpressure.
    oku(32'h0000_0040, 5, 1'b0);

    // Reset while a write is pending with counter==3.
    eski = {8{32'h1357_9BDF}};
    yaz(32'h0000_1000, eski, 1'b0);
    hazir_bekle("rstw_hazir");
    bus.istek_adres_i       = 32'h0000_1000;
    bus.istek_veri_i        = {8{32'hDEAD_BEEF}};
    bus.istek_yaz_gecerli_i = 1'b1;
    bus.istek_gecerli_i     = 1'b1;
    tick();
    bus.istek_gecerli_i = 1'b0;
    repeat (G - 4) tick();
    rst = 1'b1;
    tick();
    kontrol("rstw_hazir0", {255'd0, bus.istek_hazir_o}, 256'd0);
    kontrol("rstw_gecerli0", {255'd0, bus.yanit_gecerli_o}, 256'd0);
    kontrol("rstw_veri0", bus.yanit_veri_o, 256'd0);
    rst = 1'b0;
    for (int k = 0; k < G + 2; k++) begin
      tick();
      kontrol("rstw_sahte_yanit", {255'd0, bus.yanit_gecerli_o}, 256'd0);
    end
    oku(32'h0000_1000, 0, 1'b0);

    // Full sweep of all lines.
    for (int i = 0; i < SATIR; i++)
      yaz(32'(i) << 5, {8{32'hABCD_0000 + 32'(i)}}, 1'b0);
    for (int i = 0; i < SATIR; i++)
      oku((32'(i) << 5) | 32'(i % 32), 0, 1'b0);

    // Random mix with noisy request inputs while busy and random stalls.
    for (int n = 0; n < 80; n++) begin
      a = $urandom;
      if ($urandom_range(1, 0) == 1)
        yaz(a, rastgele_satir(), 1'b1);
      else
        oku(a, int'($urandom_range(3, 0)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
